instr_fetch: RTL and testbench

- Fetch sequencer on the consumer side of the 15-bit program counter. It reads the PC value and drives the PC's load, increment and target inputs.
- Issues one instruction-memory read at a time with a req/ack handshake.
- Buffers fetched words, tagged with their addresses, in a small FIFO toward decode, using a valid/ready handshake.
- Executes branch redirects from the execute stage: loads the PC, flushes the buffer and discards any in-flight read.

---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/instr_fetch_if.sv | 30 +++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding and the address/word
// widths it shares with the program counter and decode stage.
package instr_fetch_pkg;

   localparam int FETCH_AW = 15;
   localparam int FETCH_IW = 16;

   typedef enum logic [1:0] {
      S_BOOT,
      S_ISSUE,
      S_WAIT,
      S_FULL
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus and decode-side instruction stream of the fetch unit.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface instr_fetch_if
   import instr_fetch_pkg::*;
#(
   parameter int AW = FETCH_AW,
   parameter int IW = FETCH_IW
) ();

   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [IW-1:0] mem_rdata;

   logic          instr_valid;
   logic [IW-1:0] instr_data;
   logic [AW-1:0] instr_pc;
   logic          instr_ready;

   modport master (
      output mem_req, mem_addr, instr_valid, instr_data, instr_pc,
      input  mem_ack, mem_rdata, instr_ready
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instr_data, instr_pc,
      output mem_ack, mem_rdata, instr_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a flush input; pointers wrap modulo DEPTH (a power of two).
// The caller guarantees no push while full and no pop while empty.
module fetch_fifo #(
   parameter  int WIDTH = 31,
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: drives the PC, issues one memory read at a time and queues
// address-tagged words toward decode; branch redirects flush and restart it.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int            AW       = FETCH_AW,
   parameter int            IW       = FETCH_IW,
   parameter int            DEPTH    = 2,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_in,
   output logic          pc_load,
   output logic          pc_inc,
   output logic [AW-1:0] pc_target,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_addr,
   instr_fetch_if.master bus
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e  state_q, state_d;
   logic          discard_q, discard_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;

   logic [CW-1:0] count;
   logic          push, pop, flush;
   logic          redirect, full_after_push;
   logic          mem_req, instr_valid;
   logic [IW-1:0] head_data;
   logic [AW-1:0] head_pc;

   // Outputs are held inactive during the reset cycle, whatever the old state was.
   assign instr_valid     = !rst && (count != '0);
   assign pop             = instr_valid && bus.instr_ready;
   assign redirect        = redirect_valid && (state_q != S_BOOT);
   assign full_after_push = (count + CW'(1) - CW'(pop)) == CW'(DEPTH);

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      discard_d  = discard_q;
      mem_addr_d = mem_addr_q;
      mem_req    = 1'b0;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_target  = '0;
      push       = 1'b0;
      flush      = 1'b0;

      case (state_q)
         S_BOOT: begin
            pc_load   = 1'b1;
            pc_target = RESET_PC;
            state_d   = S_ISSUE;
         end
         S_ISSUE: begin
            if (!redirect) begin
               mem_addr_d = pc_in;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            mem_req = 1'b1;
            if (bus.mem_ack) begin
               state_d   = S_ISSUE;
               discard_d = 1'b0;
               if (!discard_q && !redirect) begin
                  push   = 1'b1;
                  pc_inc = 1'b1;
                  if (full_after_push) state_d = S_FULL;
               end
            end else if (redirect) begin
               // The request stays up; its data is dropped when the ack finally arrives.
               discard_d = 1'b1;
            end
         end
         S_FULL: begin
            if (redirect || (count < CW'(DEPTH))) state_d = S_ISSUE;
         end
         default: state_d = S_BOOT;
      endcase

      // The PC favours inc over load, so a redirect must also suppress inc.
      if (redirect) begin
         pc_load   = 1'b1;
         pc_target = redirect_addr;
         pc_inc    = 1'b0;
         flush     = 1'b1;
      end

      if (rst) begin
         mem_req   = 1'b0;
         pc_load   = 1'b0;
         pc_inc    = 1'b0;
         pc_target = '0;
         push      = 1'b0;
         flush     = 1'b0;
      end
   end

   // NOTE: state updates use non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_BOOT;
         discard_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         discard_q  <= discard_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   fetch_fifo #(
      .WIDTH (IW + AW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({bus.mem_rdata, mem_addr_q}),
      .rdata ({head_data, head_pc}),
      .count (count)
   );

   assign bus.mem_req     = mem_req;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr_valid = instr_valid;
   assign bus.instr_data  = head_data;
   assign bus.instr_pc    = head_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: a transaction-level model tracks the expected
// fetch address stream and buffered words; directed phases pin it with literals.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int            AW       = FETCH_AW;
   localparam int            IW       = FETCH_IW;
   localparam int            DEPTH    = 2;
   localparam logic [AW-1:0] RESET_PC = 15'h0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] pc_reg = 15'h1234;
   logic          pc_load, pc_inc;
   logic [AW-1:0] pc_target;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_addr  = '0;

   instr_fetch_if #(.AW(AW), .IW(IW)) bus ();

   instr_fetch #(
      .AW       (AW),
      .IW       (IW),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_in          (pc_reg),
      .pc_load        (pc_load),
      .pc_inc         (pc_inc),
      .pc_target      (pc_target),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   // PC register of the surrounding pipeline: increment takes precedence over load.
   always @(posedge clk) begin
      if (pc_inc)       pc_reg <= pc_reg + 15'd1;
      else if (pc_load) pc_reg <= pc_target;
   end

   typedef struct {
      logic [IW-1:0] data;
      logic [AW-1:0] pc;
   } entry_t;

   entry_t        q[$];
   logic [AW-1:0] exp_pc = '0;
   logic [AW-1:0] req_addr = '0;
   bit            req_active, req_stale, boot_pending;
   int            cyc, idle_cnt, n_tests, n_fail;
   bit            mem_busy, new_req_now, rand_mode;
   int            mem_wait, ack_lat;

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[6:0], a[14:6]} ^ 16'hC35A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_cycle();
      entry_t e;
      bit     ack_ok;
      cyc++;
      if (rst) begin
         check("rst_mem_req",   32'(bus.mem_req),     32'd0);
         check("rst_pc_load",   32'(pc_load),         32'd0);
         check("rst_pc_inc",    32'(pc_inc),          32'd0);
         check("rst_pc_target", 32'(pc_target),       32'd0);
         check("rst_valid",     32'(bus.instr_valid), 32'd0);
         q.delete();
         req_active   = 1'b0;
         boot_pending = 1'b1;
         idle_cnt     = 0;
         return;
      end
      if (boot_pending) begin
         boot_pending = 1'b0;
         check("boot_pc_load", 32'(pc_load),         32'd1);
         check("boot_target",  32'(pc_target),       32'(RESET_PC));
         check("boot_mem_req", 32'(bus.mem_req),     32'd0);
         check("boot_pc_inc",  32'(pc_inc),          32'd0);
         check("boot_valid",   32'(bus.instr_valid), 32'd0);
         exp_pc = RESET_PC;
         return;
      end

      check("load_inc_excl", 32'(pc_load && pc_inc), 32'd0);
      check("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("instr_data", 32'(bus.instr_data), 32'(q[0].data));
         check("instr_pc",   32'(bus.instr_pc),   32'(q[0].pc));
      end

      if (bus.mem_req) begin
         idle_cnt = 0;
         if (!req_active) begin
            check("req_addr", 32'(bus.mem_addr), 32'(exp_pc));
            check("req_room", 32'(q.size() < DEPTH), 32'd1);
            req_active = 1'b1;
            req_stale  = 1'b0;
            req_addr   = bus.mem_addr;
         end else begin
            check("req_stable", 32'(bus.mem_addr), 32'(req_addr));
         end
      end else if (q.size() < DEPTH) begin
         idle_cnt++;
         if (idle_cnt > 12) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_stall: no request for %0d cycles with room in buffer (cycle %0d)", idle_cnt, cyc);
            idle_cnt = 0;
         end
      end

      if (redirect_valid) begin
         check("redir_load",   32'(pc_load),   32'd1);
         check("redir_target", 32'(pc_target), 32'(redirect_addr));
         check("redir_inc",    32'(pc_inc),    32'd0);
      end else begin
         check("no_load", 32'(pc_load), 32'd0);
      end

      ack_ok = bus.mem_req && bus.mem_ack && !req_stale && !redirect_valid;
      check("pc_inc", 32'(pc_inc), 32'(ack_ok));

      // Advance the model: pop, then push, then redirect flush.
      if (q.size() != 0 && bus.instr_ready && !redirect_valid) void'(q.pop_front());
      if (bus.mem_req && bus.mem_ack) begin
         if (ack_ok) begin
            e.data = mem_word(req_addr);
            e.pc   = req_addr;
            q.push_back(e);
            exp_pc = exp_pc + 15'd1;
         end
         req_active = 1'b0;
      end
      if (redirect_valid) begin
         q.delete();
         exp_pc = redirect_addr;
         if (req_active) req_stale = 1'b1;
      end
   endtask

   task automatic drive_next();
      new_req_now    = 1'b0;
      redirect_valid = 1'b0;
      if (bus.mem_ack) mem_busy = 1'b0;
      bus.mem_ack = 1'b0;
      if (rst) begin
         mem_busy = 1'b0;
      end else if (bus.mem_req) begin
         if (!mem_busy) begin
            mem_busy    = 1'b1;
            new_req_now = 1'b1;
            mem_wait    = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
         end
         if (mem_wait == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_word(bus.mem_addr);
         end else begin
            mem_wait--;
            bus.mem_rdata = 16'($urandom);
         end
      end
      if (rand_mode && !rst && !boot_pending) begin
         bus.instr_ready = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 15) == 0) begin
            redirect_valid = 1'b1;
            case ($urandom_range(0, 3))
               0:       redirect_addr = 15'h7FFF;
               1:       redirect_addr = 15'h7FFE;
               default: redirect_addr = 15'($urandom);
            endcase
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      drive_next();
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Leaves the bench inside the first cycle of the next new memory request.
   task automatic wait_req(input string name);
      int n = 0;
      do begin
         step();
         n++;
      end while (!new_req_now && n < 40);
      if (!new_req_now) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no new request within 40 cycles (cycle %0d)", name, cyc);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_cyc;
      bus.mem_ack     = 1'b0;
      bus.mem_rdata   = '0;
      bus.instr_ready = 1'b1;
      ack_lat         = 0;
      rand_mode       = 1'b0;

      // Boot: sequential fetch from RESET_PC, one request every two cycles.
      do_reset();
      last_cyc = 0;
      for (int i = 0; i < 3; i++) begin
         wait_req("boot_req");
         check("boot_addr", 32'(bus.mem_addr), 32'(i));
         if (i > 0) check("boot_spacing", 32'(cyc - last_cyc), 32'd2);
         last_cyc = cyc;
      end

      // Backpressure: two words fill the buffer and fetching halts.
      do_reset();
      bus.instr_ready = 1'b0;
      repeat (10) step();
      check("bp_mem_req", 32'(bus.mem_req),     32'd0);
      check("bp_valid",   32'(bus.instr_valid), 32'd1);
      check("bp_head_pc", 32'(bus.instr_pc),    32'h0000);
      bus.instr_ready = 1'b1;
      wait_req("bp_resume");
      check("bp_resume_addr", 32'(bus.mem_addr), 32'h0002);

      // Redirect in the first WAIT cycle with a slow ack.
      do_reset();
      ack_lat = 3;
      wait_req("rw_first");
      check("rw_first_addr", 32'(bus.mem_addr), 32'h0000);
      redirect_valid = 1'b1;
      redirect_addr  = 15'h0100;
      step();
      check("rw_valid", 32'(bus.instr_valid), 32'd0);
      wait_req("rw_next");
      check("rw_next_addr", 32'(bus.mem_addr), 32'h0100);

      // Redirect coincident with the ack.
      ack_lat = 1;
      wait_req("ra_first");
      step();
      redirect_valid = 1'b1;
      redirect_addr  = 15'h0200;
      step();
      wait_req("ra_next");
      check("ra_next_addr", 32'(bus.mem_addr), 32'h0200);

      // Redirect while stalled full, with a same-cycle pop attempt.
      ack_lat         = 0;
      bus.instr_ready = 1'b0;
      repeat (8) step();
      check("rf_stalled", 32'(bus.mem_req), 32'd0);
      bus.instr_ready = 1'b1;
      redirect_valid  = 1'b1;
      redirect_addr   = 15'h0300;
      step();
      check("rf_valid", 32'(bus.instr_valid), 32'd0);
      wait_req("rf_next");
      check("rf_next_addr", 32'(bus.mem_addr), 32'h0300);

      // Address wrap is owned by the PC: 7FFF is followed by 0000.
      redirect_valid = 1'b1;
      redirect_addr  = 15'h7FFF;
      step();
      wait_req("wrap_a");
      check("wrap_addr_a", 32'(bus.mem_addr), 32'h7FFF);
      wait_req("wrap_b");
      check("wrap_addr_b", 32'(bus.mem_addr), 32'h0000);
      step();
      check("wrap_valid", 32'(bus.instr_valid), 32'd1);
      check("wrap_pc",    32'(bus.instr_pc),    32'h0000);

      // Random traffic: ack latency, decode readiness and redirects.
      ack_lat   = -1;
      rand_mode = 1'b1;
      repeat (3000) step();
      rand_mode       = 1'b0;
      bus.instr_ready = 1'b1;

      // Reset mid-operation restarts from RESET_PC.
      do_reset();
      wait_req("rst_restart");
      check("rst_restart_addr", 32'(bus.mem_addr), 32'(RESET_PC));
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
